// File: rtl/mem_access_unit_if.sv
// MEM-stage request, data-memory and load-result bundle for mem_access_unit.
// The slave modport is the unit itself; master is the pipeline/memory side.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_load;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;

  logic              stall;
  logic [ADDR_W-1:0] dm_addr;
  logic              dm_memwrite;
  logic              dm_memread;
  logic              dm_half;
  logic              dm_byte;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;

  logic              ld_valid;
  logic [4:0]        ld_rd;
  logic [31:0]       ld_data;
  logic              misalign;
  logic [ADDR_W-1:0] misalign_addr;

  modport slave (
    input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  dm_rdata,
    output stall, dm_addr, dm_memwrite, dm_memread, dm_half, dm_byte, dm_wdata,
    output ld_valid, ld_rd, ld_data, misalign, misalign_addr
  );

  modport master (
    output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output dm_rdata,
    input  stall, dm_addr, dm_memwrite, dm_memread, dm_half, dm_byte, dm_wdata,
    input  ld_valid, ld_rd, ld_data, misalign, misalign_addr
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front-end for the MEM stage: size decode, one-cycle load stall, load extension.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    LD_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic        r_ld_valid;
  logic [4:0]  r_ld_rd;
  logic [31:0] r_ld_data;

  logic        w_is_ld;
  logic        w_is_st;
  logic        w_ld_legal;
  logic        w_st_legal;
  logic        w_acc;
  logic        w_mis;
  logic        w_go;
  logic        w_fault;
  logic        w_memread;
  logic        w_memwrite;
  logic        w_stall;
  logic [31:0] w_ext;

  // A request with both load and store set is treated purely as a load.
  assign w_is_ld    = bus.req_valid & bus.req_load;
  assign w_is_st    = bus.req_valid & bus.req_store & ~bus.req_load;
  assign w_ld_legal = (bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign w_st_legal = (bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
  assign w_acc      = (w_is_ld & w_ld_legal) | (w_is_st & w_st_legal);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign w_mis = ((bus.req_funct3[1:0] == 2'b01) & bus.req_addr[0]) |
                 ((bus.req_funct3[1:0] == 2'b10) & (bus.req_addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  assign w_go    = (r_state == IDLE) & w_acc & ~w_mis;
  assign w_fault = (r_state == IDLE) & w_acc & w_mis;

  always_comb begin
    w_state_nxt = r_state;
    w_memread   = 1'b0;
    w_memwrite  = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_go && w_is_ld) begin
          w_memread   = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = LD_WAIT;
        end else if (w_go && w_is_st) begin
          w_memwrite = 1'b1;
        end
      end
      LD_WAIT: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ext = bus.dm_rdata;
    case (r_funct3)
      3'b000:  w_ext = {{24{bus.dm_rdata[7]}}, bus.dm_rdata[7:0]};
      3'b001:  w_ext = {{16{bus.dm_rdata[15]}}, bus.dm_rdata[15:0]};
      3'b100:  w_ext = {24'h0, bus.dm_rdata[7:0]};
      3'b101:  w_ext = {16'h0, bus.dm_rdata[15:0]};
      default: w_ext = bus.dm_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_funct3   <= '0;
      r_rd       <= '0;
      r_ld_valid <= 1'b0;
      r_ld_rd    <= '0;
      r_ld_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ld_valid <= (r_state == LD_WAIT);
      if (w_memread) begin
        r_funct3 <= bus.req_funct3;
        r_rd     <= bus.req_rd;
      end
      if (r_state == LD_WAIT) begin
        r_ld_data <= w_ext;
        r_ld_rd   <= r_rd;
      end
    end
  end

  // Strobes and stall are masked while reset is held so memory never sees a stray access.
  assign bus.stall       = w_stall & rst;
  assign bus.dm_memread  = w_memread & rst;
  assign bus.dm_memwrite = w_memwrite & rst;
  assign bus.dm_half     = (w_memread | w_memwrite) & rst & (bus.req_funct3[1:0] == 2'b01);
  assign bus.dm_byte     = (w_memread | w_memwrite) & rst & (bus.req_funct3[1:0] == 2'b00);
  assign bus.dm_addr     = bus.req_addr;
  assign bus.dm_wdata    = bus.req_wdata;
  assign bus.ld_valid    = r_ld_valid;
  assign bus.ld_rd       = r_ld_rd;
  assign bus.ld_data     = r_ld_data;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic              r_misalign;
  logic [ADDR_W-1:0] r_misalign_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
    end else begin
      r_misalign <= w_fault;
      if (w_fault) r_misalign_addr <= bus.req_addr;
    end
  end

  assign bus.misalign      = r_misalign;
  assign bus.misalign_addr = r_misalign_addr;
`else
  logic w_unused;
  assign w_unused          = w_fault;
  assign bus.misalign      = 1'b0;
  assign bus.misalign_addr = '0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a byte-addressed memory and reference model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0] mem     [64];
  logic [7:0] ref_mem [64];

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Data memory: registered read, zero-extended by access size, little-endian.
  always @(posedge clk) begin
    if (bus.dm_memwrite) begin
      mem[bus.dm_addr[5:0]] <= bus.dm_wdata[7:0];
      if (!bus.dm_byte) mem[6'(bus.dm_addr[5:0] + 6'd1)] <= bus.dm_wdata[15:8];
      if (!bus.dm_byte && !bus.dm_half) begin
        mem[6'(bus.dm_addr[5:0] + 6'd2)] <= bus.dm_wdata[23:16];
        mem[6'(bus.dm_addr[5:0] + 6'd3)] <= bus.dm_wdata[31:24];
      end
    end
    if (bus.dm_memread) begin
      if (bus.dm_byte)
        bus.dm_rdata <= {24'h0, mem[bus.dm_addr[5:0]]};
      else if (bus.dm_half)
        bus.dm_rdata <= {16'h0, mem[6'(bus.dm_addr[5:0] + 6'd1)], mem[bus.dm_addr[5:0]]};
      else
        bus.dm_rdata <= {mem[6'(bus.dm_addr[5:0] + 6'd3)], mem[6'(bus.dm_addr[5:0] + 6'd2)],
                         mem[6'(bus.dm_addr[5:0] + 6'd1)], mem[bus.dm_addr[5:0]]};
    end
  end

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int unsigned a);
    logic [7:0] b0, b1, b2, b3;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    int sv;
    b0 = ref_mem[a % 64];
    b1 = ref_mem[(a + 1) % 64];
    b2 = ref_mem[(a + 2) % 64];
    b3 = ref_mem[(a + 3) % 64];
    case (f3)
      3'b000:  begin sb = b0; sv = sb; return 32'(sv); end
      3'b001:  begin sh = {b1, b0}; sv = sh; return 32'(sv); end
      3'b100:  return 32'(b0);
      3'b101:  return 32'({b1, b0});
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] f3, input int unsigned a, input logic [31:0] d);
    int unsigned nb;
    nb = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    for (int unsigned i = 0; i < nb; i++) ref_mem[(a + i) % 64] = d[8*i +: 8];
  endtask

  task automatic drive_req(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    bus.req_valid  = 1'b1;
    bus.req_load   = ld;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_rd     = rd;
  endtask

  task automatic idle_req();
    bus.req_valid = 1'b0;
    bus.req_load  = 1'b0;
    bus.req_store = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b010, 32'd4, 32'h0, 5'd3);
    #1;
    n_vec++;
    if ({bus.stall, bus.dm_memread, bus.dm_memwrite, bus.ld_valid, bus.misalign} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl got stall/rd/wr/ldv/mis=%b want 00000",
               {bus.stall, bus.dm_memread, bus.dm_memwrite, bus.ld_valid, bus.misalign});
    end
    n_vec++;
    if ({bus.ld_rd, bus.ld_data, bus.misalign_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_data got ld_rd=%0d ld_data=%h mis_addr=%h want 0", bus.ld_rd, bus.ld_data, bus.misalign_addr);
    end
    idle_req();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    int unsigned ad [5] = '{0, 0, 6, 6, 4};
    logic [31:0] ex [5] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF8210, 32'h00008210, 32'h82100804};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_req(1'b1, 1'b0, f3[i], ad[i], 32'h0, 5'(i + 1));
      #1;
      n_vec++;
      if ({bus.stall, bus.dm_memread, bus.dm_memwrite} !== 3'b110 || bus.dm_addr !== ad[i]) begin
        n_err++;
        $display("FAIL load_req[%0d] got stall/rd/wr=%b addr=%0d want 110 addr=%0d",
                 i, {bus.stall, bus.dm_memread, bus.dm_memwrite}, bus.dm_addr, ad[i]);
      end
      n_vec++;
      if (bus.dm_byte !== (f3[i][1:0] == 2'b00) || bus.dm_half !== (f3[i][1:0] == 2'b01)) begin
        n_err++;
        $display("FAIL load_size[%0d] got byte=%b half=%b for funct3=%b", i, bus.dm_byte, bus.dm_half, f3[i]);
      end
      @(negedge clk);
      idle_req();
      #1;
      n_vec++;
      if ({bus.stall, bus.dm_memread, bus.ld_valid} !== 3'b000) begin
        n_err++;
        $display("FAIL load_wait[%0d] got stall/rd/ldv=%b want 000", i, {bus.stall, bus.dm_memread, bus.ld_valid});
      end
      @(negedge clk);
      n_vec++;
      if (bus.ld_valid !== 1'b1 || bus.ld_data !== ex[i] || bus.ld_rd !== 5'(i + 1)) begin
        n_err++;
        $display("FAIL load_result[%0d] got v=%b data=%h rd=%0d want 1 %h %0d",
                 i, bus.ld_valid, bus.ld_data, bus.ld_rd, ex[i], i + 1);
      end
      @(negedge clk);
      n_vec++;
      if (bus.ld_valid !== 1'b0) begin
        n_err++;
        $display("FAIL load_pulse[%0d] got ld_valid=%b want 0", i, bus.ld_valid);
      end
    end
  endtask

  task automatic test_stores();
    logic [2:0]  sf [2] = '{3'b010, 3'b000};
    int unsigned sa [2] = '{16, 20};
    logic [31:0] sd [2] = '{32'hDEADBEEF, 32'h00000080};
    logic [31:0] ex [2] = '{32'hDEADBEEF, 32'hFFFFFF80};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_req(1'b0, 1'b1, sf[i], sa[i], sd[i], 5'd0);
      #1;
      n_vec++;
      if ({bus.stall, bus.dm_memread, bus.dm_memwrite, bus.dm_byte} !== {3'b001, sf[i] == 3'b000} ||
          bus.dm_wdata !== sd[i]) begin
        n_err++;
        $display("FAIL store_req[%0d] got stall/rd/wr/byte=%b wdata=%h", i,
                 {bus.stall, bus.dm_memread, bus.dm_memwrite, bus.dm_byte}, bus.dm_wdata);
      end
      ref_store(sf[i], sa[i], sd[i]);
      @(negedge clk);
      drive_req(1'b1, 1'b0, sf[i], sa[i], 32'h0, 5'd9);
      @(negedge clk);
      idle_req();
      @(negedge clk);
      n_vec++;
      if (bus.ld_valid !== 1'b1 || bus.ld_data !== ex[i] || bus.ld_data !== ref_load(sf[i], sa[i])) begin
        n_err++;
        $display("FAIL store_readback[%0d] got v=%b data=%h want %h", i, bus.ld_valid, bus.ld_data, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b010, 32'd0, 32'h0, 5'd5);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b010, 32'd4, 32'h0, 5'd6);
    #1;
    n_vec++;
    if ({bus.stall, bus.dm_memread} !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_not_accepted got stall/rd=%b want 00", {bus.stall, bus.dm_memread});
    end
    @(negedge clk);
    n_vec++;
    if (bus.ld_valid !== 1'b1 || bus.ld_rd !== 5'd5 || bus.ld_data !== 32'h020154FF) begin
      n_err++;
      $display("FAIL b2b_first got v=%b rd=%0d data=%h want 1 5 020154ff", bus.ld_valid, bus.ld_rd, bus.ld_data);
    end
    #1;
    n_vec++;
    if ({bus.stall, bus.dm_memread} !== 2'b11) begin
      n_err++;
      $display("FAIL b2b_second_issue got stall/rd=%b want 11", {bus.stall, bus.dm_memread});
    end
    @(negedge clk);
    idle_req();
    n_vec++;
    if (bus.ld_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_gap got ld_valid=%b want 0", bus.ld_valid);
    end
    @(negedge clk);
    n_vec++;
    if (bus.ld_valid !== 1'b1 || bus.ld_rd !== 5'd6 || bus.ld_data !== 32'h82100804) begin
      n_err++;
      $display("FAIL b2b_second got v=%b rd=%0d data=%h want 1 6 82100804", bus.ld_valid, bus.ld_rd, bus.ld_data);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] lf [3] = '{3'b011, 3'b110, 3'b111};
    logic [2:0] sf [5] = '{3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 3)       drive_req(1'b1, 1'b0, lf[i], 32'd8, 32'h12345678, 5'd7);
      else if (i < 8)  drive_req(1'b0, 1'b1, sf[i-3], 32'd8, 32'h12345678, 5'd7);
      else begin
        drive_req(i == 8, i == 9, 3'b010, 32'd8, 32'h12345678, 5'd7);
        bus.req_valid = 1'b0;
      end
      #1;
      n_vec++;
      if ({bus.stall, bus.dm_memread, bus.dm_memwrite} !== 3'b000) begin
        n_err++;
        $display("FAIL illegal_req[%0d] got stall/rd/wr=%b want 000", i, {bus.stall, bus.dm_memread, bus.dm_memwrite});
      end
      @(negedge clk);
      idle_req();
      n_vec++;
      if (bus.ld_valid !== 1'b0 || bus.misalign !== 1'b0) begin
        n_err++;
        $display("FAIL illegal_result[%0d] got ldv=%b mis=%b want 0 0", i, bus.ld_valid, bus.misalign);
      end
    end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b010, 32'd1, 32'h0, 5'd4);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    #1;
    n_vec++;
    if ({bus.stall, bus.dm_memread} !== 2'b00) begin
      n_err++;
      $display("FAIL mis_req got stall/rd=%b want 00", {bus.stall, bus.dm_memread});
    end
    @(negedge clk);
    idle_req();
    n_vec++;
    if (bus.misalign !== 1'b1 || bus.misalign_addr !== 32'd1 || bus.ld_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mis_pulse got mis=%b addr=%h ldv=%b want 1 1 0", bus.misalign, bus.misalign_addr, bus.ld_valid);
    end
    @(negedge clk);
    n_vec++;
    if (bus.misalign !== 1'b0 || bus.misalign_addr !== 32'd1 || bus.ld_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mis_hold got mis=%b addr=%h ldv=%b want 0 1 0", bus.misalign, bus.misalign_addr, bus.ld_valid);
    end
`else
    @(negedge clk);
    idle_req();
    @(negedge clk);
    n_vec++;
    if (bus.ld_valid !== 1'b1 || bus.ld_data !== 32'h04020154 || bus.misalign !== 1'b0) begin
      n_err++;
      $display("FAIL unaligned_lw got v=%b data=%h mis=%b want 1 04020154 0", bus.ld_valid, bus.ld_data, bus.misalign);
    end
`endif
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b000, 32'd0, 32'h0, 5'd11);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if ({bus.stall, bus.dm_memread, bus.dm_memwrite, bus.ld_valid, bus.misalign} !== 5'b0 ||
        {bus.ld_rd, bus.ld_data, bus.misalign_addr} !== '0) begin
      n_err++;
      $display("FAIL rst_wait_outputs got ctrl=%b ld_rd=%0d ld_data=%h", {bus.stall, bus.dm_memread,
               bus.dm_memwrite, bus.ld_valid, bus.misalign}, bus.ld_rd, bus.ld_data);
    end
    @(negedge clk);
    n_vec++;
    if (bus.ld_valid !== 1'b0 || bus.dm_memread !== 1'b0) begin
      n_err++;
      $display("FAIL rst_wait_drop got ldv=%b rd=%b want 0 0", bus.ld_valid, bus.dm_memread);
    end
    rst = 1'b1;
    drive_req(1'b1, 1'b0, 3'b000, 32'd1, 32'h0, 5'd12);
    #1;
    n_vec++;
    if ({bus.stall, bus.dm_memread} !== 2'b11) begin
      n_err++;
      $display("FAIL rst_wait_idle got stall/rd=%b want 11", {bus.stall, bus.dm_memread});
    end
    @(negedge clk);
    idle_req();
    @(negedge clk);
    n_vec++;
    if (bus.ld_valid !== 1'b1 || bus.ld_data !== 32'h00000054 || bus.ld_rd !== 5'd12) begin
      n_err++;
      $display("FAIL rst_wait_after got v=%b data=%h rd=%0d want 1 00000054 12", bus.ld_valid, bus.ld_data, bus.ld_rd);
    end
  endtask

  task automatic test_random();
    logic [2:0]  lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  f3;
    int unsigned a;
    logic [31:0] wd;
    logic [4:0]  rd;
    for (int i = 0; i < 40; i++) begin
      f3 = lf[$urandom_range(0, 4)];
      a  = $urandom_range(0, 60);
      if (f3[1:0] == 2'b01) a = a & ~32'd1;
      if (f3[1:0] == 2'b10) a = a & ~32'd3;
      wd = $urandom;
      rd = 5'($urandom);
      @(negedge clk);
      if ($urandom_range(0, 1) == 0 && f3[2] == 1'b0) begin
        drive_req(1'b0, 1'b1, f3, a, wd, rd);
        #1;
        n_vec++;
        if ({bus.stall, bus.dm_memwrite} !== 2'b01) begin
          n_err++;
          $display("FAIL rand_store[%0d] got stall/wr=%b want 01", i, {bus.stall, bus.dm_memwrite});
        end
        ref_store(f3, a, wd);
        @(negedge clk);
        idle_req();
      end else begin
        drive_req(1'b1, $urandom_range(0, 1) == 1, f3, a, wd, rd);
        bus.req_load = 1'b1;
        #1;
        n_vec++;
        if ({bus.stall, bus.dm_memread, bus.dm_memwrite} !== 3'b110) begin
          n_err++;
          $display("FAIL rand_load_req[%0d] got stall/rd/wr=%b want 110", i, {bus.stall, bus.dm_memread, bus.dm_memwrite});
        end
        @(negedge clk);
        idle_req();
        @(negedge clk);
        n_vec++;
        if (bus.ld_valid !== 1'b1 || bus.ld_data !== ref_load(f3, a) || bus.ld_rd !== rd) begin
          n_err++;
          $display("FAIL rand_load[%0d] f3=%b a=%0d got v=%b data=%h rd=%0d want 1 %h %0d",
                   i, f3, a, bus.ld_valid, bus.ld_data, bus.ld_rd, ref_load(f3, a), rd);
        end
      end
    end
  endtask

  initial begin
    logic [7:0] init [8] = '{8'hFF, 8'h54, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h82};
    for (int i = 0; i < 64; i++) begin
      mem[i]     = (i < 8) ? init[i] : 8'h00;
      ref_mem[i] = mem[i];
    end
    bus.dm_rdata   = '0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_rd     = '0;
    idle_req();
    test_reset();
    test_loads();
    test_stores();
    test_back_to_back();
    test_illegal();
    test_misalign();
    test_reset_in_wait();
    test_random();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequential load/store front-end for the MEM stage of the pipelined RISC-V core, sitting directly upstream of the byte-addressed data memory. It decodes the MEM-stage request (funct3, address, store data) into the memory's word/half/byte strobes. It stalls the pipeline for one cycle to absorb the memory's registered read latency, then sign- or zero-extends the returned data and delivers a tagged load result toward the MEM/WB register. It optionally traps misaligned accesses.

## Interface
- ADDR_W, 32, address width driven to data memory
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  MEM stage holds a memory instruction
- req_load  input  1  instruction is a load
- req_store  input  1  instruction is a store
- req_funct3  input  3  RV32I funct3 of the load/store
- req_addr  input  ADDR_W  effective address from EX/MEM
- req_wdata  input  32  store data (rs2)
- req_rd  input  5  load destination register
- stall  output  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle
- dm_addr  output  ADDR_W  to data memory addr
- dm_memwrite / dm_memread  output  1 each  memory strobes
- dm_half / dm_byte  output  1 each  size selects (both 0 = word)
- dm_wdata  output  32  store data to memory
- dm_rdata  input  32  registered read data from memory (zero-extended by memory)
- ld_valid  output  1  one-cycle pulse, ld_data/ld_rd valid
- ld_rd  output  5  destination of completed load
- ld_data  output  32  extended load result
- misalign  output  1  one-cycle trap pulse (tied 0 without macro)
- misalign_addr  output  ADDR_W  faulting address

## Operation
- FSM states: IDLE, LD_WAIT.
- IDLE, req_valid & req_store & ~req_load: dm_memwrite=1 combinationally, dm_addr=req_addr, dm_wdata=req_wdata; no stall; stay IDLE.
- IDLE, req_valid & req_load: dm_memread=1, stall=1; capture funct3 and rd; go LD_WAIT.
- req_load & req_store both set: treated as load; dm_memwrite=0.
- LD_WAIT: all dm strobes 0, stall=0; extend dm_rdata per captured funct3, register into ld_data, pulse ld_valid next cycle; return IDLE.
- Size decode: 000 byte, 001 half, 010 word (dm_half/dm_byte accordingly). Loads: 000 LB sign-extend bit 7, 001 LH sign-extend bit 15, 010 LW, 100 LBU, 101 LHU zero-extend.
- Illegal funct3 (011, 110, 111; stores also 100, 101): no strobes, no stall, no ld_valid.
- req_valid=0: all dm strobes 0, stall 0.
- Reset: state IDLE; stall, ld_valid, ld_rd, ld_data, misalign, misalign_addr = 0; dm strobes forced 0 while rst low. Reset in LD_WAIT drops the load; no ld_valid follows.

## Timing
- Store: 1 cycle, zero stall; memory writes at the end of the request cycle.
- Load: request cycle N (stall=1), memory registers data at end of N, LD_WAIT cycle N+1 (stall=0, pipeline advances), ld_valid/ld_data valid in cycle N+2.
- A new request in cycle N+1 is not accepted; it is evaluated in IDLE at N+2. Back-to-back loads therefore issue every 2 cycles.
- misalign pulses in the cycle after the faulting request; misalign_addr holds until the next fault or reset.

## Configuration
- MEM_ACCESS_MISALIGN_TRAP_EN defined: half access with addr[0]=1, or word access with addr[1:0]≠0, asserts no strobes and no stall, registers misalign=1 and misalign_addr=req_addr; no ld_valid.
- Undefined: misalign tied 0, misalign_addr tied 0; misaligned accesses pass through to memory as normal (memory is byte-addressed).

## Test plan
- Memory preloaded with bytes 0..7 = FF,54,01,02,04,08,10,82. LB addr 0 -> ld_valid two cycles later, ld_data=0xFFFFFFFF. LBU addr 0 -> 0x000000FF.
- LH addr 6 -> 0xFFFF8210. LHU addr 6 -> 0x00008210. LW addr 4 -> 0x82100804. stall high exactly one cycle each.
- SW 0xDEADBEEF addr 16, then LW addr 16 -> 0xDEADBEEF. SB 0x80 addr 20, then LB addr 20 -> 0xFFFFFF80. Stores show no stall.
- Back-to-back LW addr 0, LW addr 4 with ld_rd 5, 6 -> ld_valid pulses 2 cycles apart, ld_rd 5 then 6, data 0x020154FF then 0x82100804.
- With macro: LW addr 1 -> misalign=1 next cycle, misalign_addr=1, dm_memread never asserted, no ld_valid. Without macro: LW addr 1 -> 0x04020154.
- rst low during LD_WAIT -> ld_valid stays 0, all outputs 0, FSM IDLE. A subsequent LB addr 1 returns 0x00000054.
